// File: rtl/exp_stream_driver_if.sv
// Str/Ack request channel between the stream driver (master) and the exponential unit (slave).
interface exp_stream_driver_if #(
  parameter int DW = 32
);
  logic          str;
  logic [DW-1:0] data;
  logic          ack;
  logic [DW-1:0] result;

  modport master (output str, output data, input ack, input result);
  modport slave  (input str, input data, output ack, output result);
endinterface

// File: rtl/exp_stream_driver.sv
// Buffers a short vector, feeds it one word at a time to the exponential unit
// over Str/Ack, and keeps the returned words for indexed readout.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | accept loads, wait for start
// S_ISSUE  | present inbuf[idx] and raise str
// S_WAIT   | hold request until ack, or give up when the timer expires
// S_GAP    | str low for one cycle, step to next element or finish
// S_FINISH | one-cycle done pulse, buffer emptied
module exp_stream_driver #(
  parameter int DATALENGTH = 32,
  parameter int INPUTMAX   = 5,
  parameter int TIMEOUT    = 64
) (
  input  logic                  clk_sys,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic [DATALENGTH-1:0] in_data,
  input  logic                  start,
  exp_stream_driver_if.master   exp,
  input  logic [2:0]            out_index,
  output logic [DATALENGTH-1:0] out_data,
  output logic [2:0]            count,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);
  localparam int         TW   = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [2:0] MAXC = 3'(INPUTMAX);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_GAP, S_FINISH} state_t;

  state_t                state, state_nx;
  logic [DATALENGTH-1:0] inbuf  [INPUTMAX];
  logic [DATALENGTH-1:0] result [INPUTMAX];
  logic [2:0]            idx;
  logic [TW-1:0]         tmo_cnt;
  logic                  str_q;
  logic [DATALENGTH-1:0] data_q;
  logic                  load_ok;
  logic [2:0]            eff_cnt;
  logic                  tmo_hit;
  logic                  last_elem;

  always_comb begin
    load_ok   = (state == S_IDLE) && in_valid && (count < MAXC);
    // a word loaded in the start cycle is part of the vector
    eff_cnt   = count + {2'b00, load_ok};
    tmo_hit   = (tmo_cnt == '0);
    last_elem = (idx == count - 3'd1);
    state_nx  = state;
    case (state)
      S_IDLE:   if (start) state_nx = (eff_cnt != 3'd0) ? S_ISSUE : S_FINISH;
      S_ISSUE:  state_nx = S_WAIT;
      S_WAIT: begin
        if (exp.ack)      state_nx = S_GAP;
        else if (tmo_hit) state_nx = S_IDLE;
      end
      S_GAP:    state_nx = last_elem ? S_FINISH : S_ISSUE;
      S_FINISH: state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < INPUTMAX; i++) begin
        inbuf[i]  <= '0;
        result[i] <= '0;
      end
      idx     <= '0;
      tmo_cnt <= '0;
      str_q   <= 1'b0;
      data_q  <= '0;
      count   <= '0;
      error   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (load_ok) begin
            inbuf[count] <= in_data;
            count        <= count + 3'd1;
          end
          if (start && (eff_cnt != 3'd0)) begin
            error <= 1'b0;
            idx   <= '0;
          end
        end
        S_ISSUE: begin
          data_q  <= inbuf[idx];
          str_q   <= 1'b1;
          tmo_cnt <= TW'(TIMEOUT - 1);
        end
        S_WAIT: begin
          if (exp.ack) begin
            result[idx] <= exp.result;
            str_q       <= 1'b0;
          end else if (tmo_hit) begin
            error <= 1'b1;
            str_q <= 1'b0;
            count <= '0;
          end else begin
            tmo_cnt <= tmo_cnt - 1'b1;
          end
        end
        S_GAP:    if (!last_elem) idx <= idx + 3'd1;
        S_FINISH: count <= '0;
        default: ;
      endcase
    end
  end

  assign exp.str  = str_q;
  assign exp.data = data_q;
  assign busy     = (state == S_ISSUE) || (state == S_WAIT) || (state == S_GAP);
  assign done     = (state == S_FINISH);

  always_comb begin
    out_data = '0;
    if (out_index < MAXC) out_data = result[out_index];
  end
endmodule

// File: tb/tb_exp_stream_driver.sv
// Self-checking bench: exponential-unit responder, handshake monitor, table vectors,
// directed corner sequences and randomized vectors against a result-buffer model.
module tb_exp_stream_driver;
  logic        clk_sys = 1'b0;
  logic        rst_n;
  logic        in_valid, start;
  logic [31:0] in_data;
  logic [2:0]  out_index;
  logic [31:0] out_data;
  logic [2:0]  count;
  logic        busy, done, error;

  exp_stream_driver_if #(.DW(32)) eif ();

  exp_stream_driver #(.DATALENGTH(32), .INPUTMAX(5), .TIMEOUT(64)) dut (
    .clk_sys(clk_sys), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .start(start), .exp(eif), .out_index(out_index), .out_data(out_data),
    .count(count), .busy(busy), .done(done), .error(error));

  always #5 clk_sys = ~clk_sys;

  int n_pass = 0, n_tot = 0;
  int resp_lat = 1;      // -1: never ack, 0: random 1..4 per element
  int ack_upto = 1000000;
  bit spur_ack = 1'b0;

  // monitor state, written only by the responder process
  int cyc = 0, rises = 0, done_cnt = 0, stab_err = 0;
  int str_len = 0, last_str_len = 0, ack_cyc = 0, done_cyc = 0, str_cyc = 0, cur_lat = 1;
  logic        prev_str = 1'b0;
  logic [31:0] prev_data = '0;
  logic [31:0] issued[$];

  logic [31:0] mres[8];

  function automatic logic [31:0] exp_fn(input logic [31:0] d);
    return (d == 32'h3f800000) ? 32'h402DF854 : (d ^ 32'hA5A55A5A);
  endfunction

  always @(negedge clk_sys) begin
    cyc++;
    if (done === 1'b1) begin done_cnt++; done_cyc = cyc; end
    if (eif.str && !prev_str) begin
      rises++;
      issued.push_back(eif.data);
      str_cyc = 0;
      cur_lat = (resp_lat == 0) ? int'($urandom_range(1, 4)) : resp_lat;
    end
    if (eif.str && prev_str && (eif.data !== prev_data)) stab_err++;
    if (eif.str) str_len++;
    else if (prev_str) begin last_str_len = str_len; str_len = 0; end
    if (eif.str) begin
      str_cyc++;
      if (resp_lat >= 0 && rises <= ack_upto && str_cyc == cur_lat) begin
        eif.ack    = 1'b1;
        eif.result = exp_fn(eif.data);
        ack_cyc    = cyc;
      end else begin
        eif.ack    = 1'b0;
        eif.result = '0;
      end
    end else begin
      eif.ack    = spur_ack;
      eif.result = spur_ack ? 32'hDEADBEEF : 32'h0;
    end
    prev_str  = eif.str;
    prev_data = eif.data;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_tot++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, expv);
  endtask

  task automatic rd(input int i, output logic [31:0] v);
    out_index = 3'(i);
    #1;
    v = out_data;
  endtask

  // load words (start optionally merged with the last load), start, wait for done
  task automatic run_vec(input logic [31:0] w[$], input bit merge, output logic err_s);
    int d0;
    int k;
    d0 = done_cnt;
    err_s = 1'bx;
    for (int i = 0; i < w.size(); i++) begin
      @(negedge clk_sys);
      in_valid = 1'b1;
      in_data  = w[i];
      start    = merge && (i == w.size() - 1);
    end
    @(negedge clk_sys);
    in_valid = 1'b0;
    start    = 1'b0;
    if (merge) err_s = error;
    else begin
      start = 1'b1;
      @(negedge clk_sys);
      start = 1'b0;
      err_s = error;
    end
    for (int t = 0; t < 3000 && done_cnt == d0; t++) @(negedge clk_sys);
    repeat (3) @(negedge clk_sys);
    k = (w.size() < 5) ? w.size() : 5;
    for (int i = 0; i < k; i++) mres[i] = exp_fn(w[i]);
  endtask

  typedef struct {
    int          idx;
    logic [31:0] word;
    logic [31:0] expect_res;
  } vec_t;

  initial begin
    vec_t        tbl[8];
    logic [31:0] w[$];
    logic [31:0] v;
    logic        es;
    int r0, d0, b0;

    tbl[0] = '{0, 32'h00000000, 32'hA5A55A5A};
    tbl[1] = '{1, 32'h3f800000, 32'h402DF854};
    tbl[2] = '{2, 32'h40000000, 32'hE5A55A5A};
    tbl[3] = '{3, 32'hbf800000, 32'h1A255A5A};
    tbl[4] = '{4, 32'h3f000000, 32'h9AA55A5A};
    tbl[5] = '{5, 32'h00000000, 32'h00000000};
    tbl[6] = '{6, 32'h00000000, 32'h00000000};
    tbl[7] = '{7, 32'h00000000, 32'h00000000};
    for (int i = 0; i < 8; i++) mres[i] = '0;

    rst_n = 1'b0; in_valid = 1'b0; start = 1'b0; in_data = '0; out_index = '0;
    repeat (3) @(negedge clk_sys);
    chk("rst_str", {31'b0, eif.str}, 32'd0);
    chk("rst_data", eif.data, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_error", {31'b0, error}, 32'd0);
    chk("rst_count", {29'b0, count}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk_sys);

    // single element, ack latency 3
    resp_lat = 3; r0 = rises; d0 = done_cnt; b0 = issued.size();
    w = '{32'h3f800000};
    run_vec(w, 1'b0, es);
    chk("t1_rises", rises - r0, 1);
    chk("t1_issued", issued[b0], 32'h3f800000);
    chk("t1_str_len", last_str_len, 3);
    chk("t1_ack_to_done", done_cyc - ack_cyc, 2);
    chk("t1_done_cnt", done_cnt - d0, 1);
    chk("t1_count", {29'b0, count}, 32'd0);
    rd(0, v); chk("t1_out0", v, 32'h402DF854);

    // five elements, latency 1, table-driven readback
    resp_lat = 1; r0 = rises; d0 = done_cnt; b0 = issued.size();
    w = {};
    for (int i = 0; i < 5; i++) w.push_back(tbl[i].word);
    run_vec(w, 1'b0, es);
    chk("t2_rises", rises - r0, 5);
    chk("t2_done_cnt", done_cnt - d0, 1);
    for (int i = 0; i < 8; i++) begin
      if (i < 5) chk($sformatf("t2_issue%0d", i), issued[b0 + i], tbl[i].word);
      rd(tbl[i].idx, v);
      chk($sformatf("t2_out%0d", tbl[i].idx), v, tbl[i].expect_res);
    end

    // six loads saturate at five
    resp_lat = 2; r0 = rises; d0 = done_cnt; b0 = issued.size();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_sys); in_valid = 1'b1; in_data = 32'h11110000 + 32'(i);
    end
    @(negedge clk_sys); in_valid = 1'b0;
    chk("t3_count_sat", {29'b0, count}, 32'd5);
    start = 1'b1; @(negedge clk_sys); start = 1'b0;
    for (int t = 0; t < 200 && done_cnt == d0; t++) @(negedge clk_sys);
    repeat (2) @(negedge clk_sys);
    chk("t3_rises", rises - r0, 5);
    chk("t3_last_issued", issued[b0 + 4], 32'h11110004);
    chk("t3_done_cnt", done_cnt - d0, 1);
    for (int i = 0; i < 5; i++) mres[i] = exp_fn(32'h11110000 + 32'(i));
    rd(4, v); chk("t3_out4", v, mres[4]);

    // timeout, then recovery clears error
    resp_lat = -1; d0 = done_cnt;
    @(negedge clk_sys); in_valid = 1'b1; in_data = 32'h40400000; start = 1'b1;
    @(negedge clk_sys); in_valid = 1'b0; start = 1'b0;
    for (int t = 0; t < 200 && error !== 1'b1; t++) @(negedge clk_sys);
    @(negedge clk_sys);
    chk("t4_error", {31'b0, error}, 32'd1);
    chk("t4_str_len", last_str_len, 64);
    chk("t4_str_low", {31'b0, eif.str}, 32'd0);
    chk("t4_no_done", done_cnt - d0, 0);
    chk("t4_count", {29'b0, count}, 32'd0);
    chk("t4_busy", {31'b0, busy}, 32'd0);
    rd(0, v); chk("t4_out0_kept", v, mres[0]);
    resp_lat = 1; d0 = done_cnt;
    w = '{32'h40800000};
    run_vec(w, 1'b0, es);
    chk("t4_error_cleared", {31'b0, es}, 32'd0);
    chk("t4_recover_done", done_cnt - d0, 1);
    rd(0, v); chk("t4_recover_out0", v, exp_fn(32'h40800000));

    // empty start, spurious acks
    r0 = rises; d0 = done_cnt;
    @(negedge clk_sys); start = 1'b1;
    @(negedge clk_sys); start = 1'b0;
    repeat (2) @(negedge clk_sys);
    chk("t5_empty_done", done_cnt - d0, 1);
    chk("t5_empty_no_str", rises - r0, 0);
    spur_ack = 1'b1;
    repeat (4) @(negedge clk_sys);
    spur_ack = 1'b0;
    @(negedge clk_sys);
    rd(0, v); chk("t5_spur_out0", v, mres[0]);
    rd(1, v); chk("t5_spur_out1", v, mres[1]);

    // reset during WAIT on element 2
    resp_lat = 2; r0 = rises; ack_upto = rises + 2;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_sys); in_valid = 1'b1; in_data = 32'h22220000 + 32'(i);
    end
    @(negedge clk_sys); in_valid = 1'b0; start = 1'b1;
    @(negedge clk_sys); start = 1'b0;
    for (int t = 0; t < 200 && rises < r0 + 3; t++) @(negedge clk_sys);
    chk("t6_reached_elem2", rises - r0, 3);
    repeat (2) @(negedge clk_sys);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_str", {31'b0, eif.str}, 32'd0);
    chk("t6_busy", {31'b0, busy}, 32'd0);
    chk("t6_count", {29'b0, count}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      rd(i, v); chk($sformatf("t6_out%0d", i), v, 32'd0);
    end
    for (int i = 0; i < 8; i++) mres[i] = '0;
    ack_upto = 1000000;
    @(negedge clk_sys); @(negedge clk_sys);
    rst_n = 1'b1;
    d0 = done_cnt; b0 = issued.size();
    w = '{32'hC0000000};
    run_vec(w, 1'b1, es);
    chk("t6_after_done", done_cnt - d0, 1);
    chk("t6_after_issue", issued[b0], 32'hC0000000);
    rd(0, v); chk("t6_after_out0", v, exp_fn(32'hC0000000));
    rd(1, v); chk("t6_after_out1", v, 32'd0);

    // randomized vectors against the result-buffer model
    resp_lat = 0;
    for (int n = 0; n < 20; n++) begin
      int len;
      int k;
      bit merge;
      len = $urandom_range(1, 7);
      merge = $urandom_range(0, 1) == 1;
      w = {};
      for (int i = 0; i < len; i++) w.push_back($urandom());
      k = (len < 5) ? len : 5;
      r0 = rises; d0 = done_cnt; b0 = issued.size();
      run_vec(w, merge, es);
      chk($sformatf("r%0d_rises", n), rises - r0, k);
      chk($sformatf("r%0d_done", n), done_cnt - d0, 1);
      chk($sformatf("r%0d_count", n), {29'b0, count}, 32'd0);
      chk($sformatf("r%0d_error", n), {31'b0, error}, 32'd0);
      for (int i = 0; i < k; i++)
        if (b0 + i < issued.size())
          chk($sformatf("r%0d_issue%0d", n, i), issued[b0 + i], w[i]);
      for (int i = 0; i < 8; i++) begin
        rd(i, v); chk($sformatf("r%0d_out%0d", n, i), v, mres[i]);
      end
    end

    chk("data_stable_while_str", stab_err, 0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
